div_radix2: RTL and testbench

- Iterative radix-2 restoring divider; the responder side of the divide handshake issued by the multiply/divide unit in the execute stage.
- Implements DIV, DIVU, REM, REMU and the 32-bit W variants with RV64M semantics, including the divide-by-zero and overflow results.
- Accepts one request at a time. Returns quotient and remainder together and holds them until the requester takes them.

---
 rtl/div_radix2_pkg.sv | 8 +
 rtl/div_radix2_if.sv | 28 ++
 rtl/div_radix2.sv | 140 ++++++++++++++
 tb/tb_div_radix2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_radix2_pkg.sv
// Shared constants and types for the multiply/divide unit.
package mdu_pkg;
  localparam int MDU_XLEN  = 64;
  localparam int MDU_WLEN  = 32;
  localparam int DIV_CNT_W = $clog2(MDU_XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_radix2_if.sv
// Divide request/response handshake between the MDU (master) and the divider (slave).
interface div_radix2_if
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
);
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic            sign;
  logic            shorten;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output flush, req_valid, sign, shorten, dividend, divisor, resp_ready,
    input  req_ready, resp_valid, quotient, remainder
  );

  modport slave (
    input  flush, req_valid, sign, shorten, dividend, divisor, resp_ready,
    output req_ready, resp_valid, quotient, remainder
  );
endinterface

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider with RV64M DIV/DIVU/REM/REMU(W) semantics.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_radix2
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int WLEN = MDU_WLEN
) (
  input  logic        clk,
  input  logic        rst,
  div_radix2_if.slave bus
);
  typedef logic [XLEN-1:0] word_t;

  localparam logic [DIV_CNT_W-1:0] LAST_X = DIV_CNT_W'(XLEN - 1);
  localparam logic [DIV_CNT_W-1:0] LAST_W = DIV_CNT_W'(WLEN - 1);

  function automatic word_t cond_neg(input word_t v, input logic neg);
    return neg ? word_t'(-v) : v;
  endfunction

  function automatic word_t sext_w(input word_t v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
  endfunction

  div_state_t            state;
  logic [DIV_CNT_W-1:0]  cnt;
  word_t                 rem, quo, dvs;
  word_t                 quotient_r, remainder_r;
  logic                  neg_q, neg_r, shorten_q, resp_valid_r;

  logic signed [XLEN-1:0] a_sx, b_sx;
  word_t                  a_w, a_mag, b_mag, min_val, sp_q, sp_r, q_fix, r_fix;
  logic                   a_neg, b_neg, div_zero, ovf, accept;
  logic [XLEN:0]          rem_sh, diff;

  assign bus.req_ready  = rst && (state == IDLE) && !bus.flush;
  assign bus.resp_valid = resp_valid_r;
  assign bus.quotient   = quotient_r;
  assign bus.remainder  = remainder_r;

  // Entry: operand width selection, sign-magnitude split, special-case detection
  always_comb begin
    a_w = bus.shorten ? sext_w(bus.dividend) : bus.dividend;
    if (bus.shorten && !bus.sign) begin
      a_sx = $signed({{(XLEN-WLEN){1'b0}}, bus.dividend[WLEN-1:0]});
      b_sx = $signed({{(XLEN-WLEN){1'b0}}, bus.divisor[WLEN-1:0]});
    end else if (bus.shorten) begin
      a_sx = $signed(sext_w(bus.dividend));
      b_sx = $signed(sext_w(bus.divisor));
    end else begin
      a_sx = $signed(bus.dividend);
      b_sx = $signed(bus.divisor);
    end
    a_neg    = bus.sign && a_sx[XLEN-1];
    b_neg    = bus.sign && b_sx[XLEN-1];
    a_mag    = cond_neg(word_t'(a_sx), a_neg);
    b_mag    = cond_neg(word_t'(b_sx), b_neg);
    min_val  = bus.shorten ? sext_w(word_t'(1) << (WLEN - 1)) : (word_t'(1) << (XLEN - 1));
    div_zero = (word_t'(b_sx) == '0);
    ovf      = bus.sign && (word_t'(a_sx) == min_val) && (word_t'(b_sx) == '1);
    sp_q     = div_zero ? '1 : a_w;
    sp_r     = div_zero ? a_w : '0;
    accept   = bus.req_valid && bus.req_ready;

    // Iteration: trial subtract over N+1 bits; bit XLEN is the borrow
    rem_sh = {rem, quo[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};

    // Exit: restore signs, then narrow W results back to XLEN
    q_fix = cond_neg(quo, neg_q);
    r_fix = cond_neg(rem, neg_r);
    if (shorten_q) begin
      q_fix = sext_w(q_fix);
      r_fix = sext_w(r_fix);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      quotient_r   <= '0;
      remainder_r  <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      shorten_q    <= 1'b0;
      resp_valid_r <= 1'b0;
    end else if (bus.flush) begin
      state        <= IDLE;
      resp_valid_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          shorten_q <= bus.shorten;
          neg_q     <= a_neg ^ b_neg;
          neg_r     <= a_neg;
          cnt       <= '0;
          rem       <= '0;
          // W operands are parked in the top half so MSB-first shifting starts at bit 31
          quo       <= bus.shorten ? (a_mag << (XLEN - WLEN)) : a_mag;
          dvs       <= b_mag;
          if (div_zero || ovf) begin
            quotient_r   <= sp_q;
            remainder_r  <= sp_r;
            resp_valid_r <= 1'b1;
            state        <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          if (!diff[XLEN]) begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= rem_sh[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == (shorten_q ? LAST_W : LAST_X)) state <= FIX;
        end
        FIX: begin
          quotient_r   <= q_fix;
          remainder_r  <= r_fix;
          resp_valid_r <= 1'b1;
          state        <= DONE;
        end
        DONE: if (bus.resp_ready) begin
          resp_valid_r <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed RV64M corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_radix2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  div_radix2_if #(.XLEN(64)) bus();

  div_radix2 #(.XLEN(64), .WLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: RV64M divide semantics from plain SV arithmetic.
  function automatic void ref_div(input logic s, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output bit special);
    logic [31:0] au, bu, q32, r32;
    logic signed [31:0] as32, bs32;
    logic signed [63:0] as64, bs64;
    if (w) begin
      au = a[31:0]; bu = b[31:0]; as32 = a[31:0]; bs32 = b[31:0];
      if (bu == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = au; special = 1;
      end else if (s && au == 32'h8000_0000 && bu == 32'hFFFF_FFFF) begin
        q32 = au; r32 = 32'd0; special = 1;
      end else if (s) begin
        q32 = as32 / bs32; r32 = as32 % bs32; special = 0;
      end else begin
        q32 = au / bu; r32 = au % bu; special = 0;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      as64 = a; bs64 = b;
      if (b == 64'd0) begin
        q = '1; r = a; special = 1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0; special = 1;
      end else if (s) begin
        q = as64 / bs64; r = as64 % bs64; special = 0;
      end else begin
        q = a / b; r = a % b; special = 0;
      end
    end
  endfunction

  task automatic gen_op(output logic s, output logic w, output logic [63:0] a, output logic [63:0] b);
    int mode;
    mode = $urandom_range(0, 5);
    s = 1'($urandom); w = 1'($urandom);
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    case (mode)
      1: b = 64'($urandom_range(1, 1000));
      2: b = {$urandom, 32'd0} & (w ? 64'hFFFF_FFFF_0000_0000 : 64'd0);
      3: begin
        s = 1'b1;
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end
      4: b = -64'($urandom_range(1, 1000));
      5: a = 64'($urandom_range(0, 50));
      default: ;
    endcase
  endtask

  // Issue one request, return the response and the accept-to-resp_valid latency.
  // Leaves the response pending (resp_ready=0), sampled at a falling edge.
  task automatic run_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] q, output logic [63:0] r, output int lat, output bit busy_ok);
    int g;
    @(negedge clk);
    bus.sign = s; bus.shorten = w; bus.dividend = a; bus.divisor = b; bus.req_valid = 1'b1;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.dividend = {$urandom, $urandom}; bus.divisor = {$urandom, $urandom};
    bus.sign = 1'($urandom); bus.shorten = 1'($urandom);
    busy_ok = (g < 20);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk); lat++;
      if (bus.resp_valid === 1'b1) break;
      if (bus.req_ready !== 1'b0) busy_ok = 0;
    end
    q = bus.quotient; r = bus.remainder;
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); end
    checks++; if (bus.quotient !== 64'd0 || bus.remainder !== 64'd0) begin failures++; $display("FAIL reset_outputs got q=%h r=%h want 0", bus.quotient, bus.remainder); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", bus.req_ready); end
  endtask

  task automatic test_unsigned();
    logic [63:0] q, r; int lat; bit busy;
    run_op(1'b0, 1'b0, 64'd100, 64'd7, q, r, lat, busy);
    checks++; if (q !== 64'd14 || r !== 64'd2) begin failures++; $display("FAIL divu_100_7 got q=%0d r=%0d want q=14 r=2", q, r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL divu_latency got=%0d want=66", lat); end
    checks++; if (!busy) begin failures++; $display("FAIL divu_busy req_ready rose during op, want 0"); end
    consume();
  endtask

  task automatic test_signed();
    logic [63:0] q, r; int lat; bit busy;
    run_op(1'b1, 1'b0, -64'd7, 64'd2, q, r, lat, busy);
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFD || r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL div_m7_2 got q=%h r=%h want q=fffffffffffffffd r=ffffffffffffffff", q, r); end
    consume();
    run_op(1'b1, 1'b0, 64'd7, -64'd2, q, r, lat, busy);
    checks++; if (q !== -64'd3 || r !== 64'd1) begin failures++; $display("FAIL div_7_m2 got q=%h r=%h want q=fffffffffffffffd r=1", q, r); end
    checks++; if (lat !== 66) begin failures++; $display("FAIL div_signed_latency got=%0d want=66", lat); end
    consume();
  endtask

  task automatic test_div_zero();
    logic [63:0] q, r; int lat; bit busy;
    run_op(1'b0, 1'b0, 64'd5, 64'd0, q, r, lat, busy);
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'd5) begin failures++; $display("FAIL divu_zero got q=%h r=%h want q=ffffffffffffffff r=5", q, r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL divu_zero_latency got=%0d want=1", lat); end
    consume();
    run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd0, q, r, lat, busy);
    checks++; if (r !== 64'hFFFF_FFFF_8000_0000 || q !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL remw_zero got q=%h r=%h want q=ffffffffffffffff r=ffffffff80000000", q, r); end
    consume();
  endtask

  task automatic test_overflow();
    logic [63:0] q, r; int lat; bit busy;
    run_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, q, r, lat, busy);
    checks++; if (q !== 64'h8000_0000_0000_0000 || r !== 64'd0) begin failures++; $display("FAIL div_ovf got q=%h r=%h want q=8000000000000000 r=0", q, r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_ovf_latency got=%0d want=1", lat); end
    consume();
    run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, q, r, lat, busy);
    checks++; if (q !== 64'hFFFF_FFFF_8000_0000 || r !== 64'd0) begin failures++; $display("FAIL divw_ovf got q=%h r=%h want q=ffffffff80000000 r=0", q, r); end
    consume();
  endtask

  task automatic test_w_unsigned();
    logic [63:0] q, r; int lat; bit busy;
    run_op(1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001, q, r, lat, busy);
    checks++; if (q !== 64'hFFFF_FFFF_FFFF_FFFF || r !== 64'd0) begin failures++; $display("FAIL divuw got q=%h r=%h want q=ffffffffffffffff r=0", q, r); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL divuw_latency got=%0d want=34", lat); end
    consume();
  endtask

  task automatic test_hold();
    logic [63:0] a, b, q, r, eq, er; int lat; bit busy, sp;
    a = {$urandom | 32'h1000_0000, $urandom}; b = 64'($urandom_range(3, 99));
    ref_div(1'b0, 1'b0, a, b, eq, er, sp);
    run_op(1'b0, 1'b0, a, b, q, r, lat, busy);
    checks++; if (q !== eq || r !== er) begin failures++; $display("FAIL hold_result got q=%h r=%h want q=%h r=%h", q, r, eq, er); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.quotient !== eq || bus.remainder !== er) begin
        failures++; $display("FAIL hold_stable cycle=%0d got v=%b q=%h r=%h want v=1 q=%h r=%h", i, bus.resp_valid, bus.quotient, bus.remainder, eq, er);
      end
    end
    consume();
    @(negedge clk);
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL hold_consumed resp_valid got=%b want=0", bus.resp_valid); end
  endtask

  task automatic test_flush();
    int g; bit seen;
    @(negedge clk);
    bus.sign = 1'b0; bus.shorten = 1'b0; bus.dividend = 64'd123456789; bus.divisor = 64'd11; bus.req_valid = 1'b1;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_low got=%b want=0", bus.req_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL flush_idle got ready=%b v=%b want ready=1 v=0", bus.req_ready, bus.resp_valid); end
    seen = 0;
    repeat (80) begin @(negedge clk); if (bus.resp_valid !== 1'b0) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL flush_no_resp got resp_valid=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    int g; bit seen;
    @(negedge clk);
    bus.sign = 1'b1; bus.shorten = 1'b0; bus.dividend = -64'd99999; bus.divisor = 64'd13; bus.req_valid = 1'b1;
    g = 0;
    while (bus.req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.quotient !== 64'd0 || bus.remainder !== 64'd0) begin failures++; $display("FAIL reset_mid got v=%b q=%h r=%h want all 0", bus.resp_valid, bus.quotient, bus.remainder); end
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_mid_ready got=%b want=0", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (80) begin @(negedge clk); if (bus.resp_valid !== 1'b0) seen = 1; end
    checks++; if (seen || bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_mid_after got seen_resp=%b ready=%b want 0/1", seen, bus.req_ready); end
  endtask

  task automatic test_random();
    logic s, w; logic [63:0] a, b, q, r, eq, er; int lat, elat; bit busy, sp;
    for (int i = 0; i < 40; i++) begin
      gen_op(s, w, a, b);
      ref_div(s, w, a, b, eq, er, sp);
      elat = sp ? 1 : (w ? 34 : 66);
      run_op(s, w, a, b, q, r, lat, busy);
      checks++;
      if (q !== eq || r !== er || lat !== elat || !busy) begin
        failures++;
        $display("FAIL random_%0d s=%b w=%b a=%h b=%h got q=%h r=%h lat=%0d busy=%b want q=%h r=%h lat=%0d", i, s, w, a, b, q, r, lat, busy, eq, er, elat);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic s, w; logic [63:0] a, b, q, r, eq, er; int lat; bit busy, sp;
    a = {$urandom, $urandom}; b = 64'($urandom_range(2, 500));
    ref_div(1'b1, 1'b0, a, b, eq, er, sp);
    run_op(1'b1, 1'b0, a, b, q, r, lat, busy);
    checks++; if (q !== eq || r !== er) begin failures++; $display("FAIL b2b_first got q=%h r=%h want q=%h r=%h", q, r, eq, er); end
    gen_op(s, w, a, b);
    ref_div(s, w, a, b, eq, er, sp);
    bus.sign = s; bus.shorten = w; bus.dividend = a; bus.divisor = b;
    bus.req_valid = 1'b1; bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_no_same_cycle_accept ready got=%b want=0", bus.req_ready); end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_next_ready got ready=%b v=%b want 1/0", bus.req_ready, bus.resp_valid); end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (lat < 200) begin @(negedge clk); lat++; if (bus.resp_valid === 1'b1) break; end
    checks++;
    if (bus.quotient !== eq || bus.remainder !== er || lat !== (sp ? 1 : (w ? 34 : 66))) begin
      failures++; $display("FAIL b2b_second got q=%h r=%h lat=%0d want q=%h r=%h", bus.quotient, bus.remainder, lat, eq, er);
    end
    consume();
  endtask

  initial begin
    bus.flush = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    bus.sign = 1'b0; bus.shorten = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_w_unsigned();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
